// File: rtl/dec3r_stage_pkg.sv
// Shared op codes, unit classes and the decoded-field record for the 3R decode stage.
// Op codes are dense so downstream issue logic can index tables directly.
package dec3r_stage_pkg;

   localparam logic [4:0] _3R_ADD   = 5'd0;
   localparam logic [4:0] _3R_SUB   = 5'd1;
   localparam logic [4:0] _3R_SLT   = 5'd2;
   localparam logic [4:0] _3R_SLTU  = 5'd3;
   localparam logic [4:0] _3R_NOR   = 5'd4;
   localparam logic [4:0] _3R_AND   = 5'd5;
   localparam logic [4:0] _3R_OR    = 5'd6;
   localparam logic [4:0] _3R_XOR   = 5'd7;
   localparam logic [4:0] _3R_SLL   = 5'd8;
   localparam logic [4:0] _3R_SRL   = 5'd9;
   localparam logic [4:0] _3R_SRA   = 5'd10;
   localparam logic [4:0] _3R_MUL   = 5'd11;
   localparam logic [4:0] _3R_MULH  = 5'd12;
   localparam logic [4:0] _3R_MULHU = 5'd13;
   localparam logic [4:0] _3R_DIV   = 5'd14;
   localparam logic [4:0] _3R_MOD   = 5'd15;
   localparam logic [4:0] _3R_DIVU  = 5'd16;
   localparam logic [4:0] _3R_MODU  = 5'd17;
   localparam logic [4:0] INVALID_OP_5B = 5'h1f;

   localparam logic [1:0] UNIT_ALU  = 2'd0;
   localparam logic [1:0] UNIT_MUL  = 2'd1;
   localparam logic [1:0] UNIT_DIV  = 2'd2;
   localparam logic [1:0] UNIT_NONE = 2'd3;

   typedef struct packed {
      logic [4:0] op;
      logic [1:0] unit;
      logic [4:0] rd;
      logic [4:0] rj;
      logic [4:0] rk;
      logic       wen;
      logic       illegal;
   } meta_t;

   localparam meta_t META_RST = '{op: INVALID_OP_5B, unit: UNIT_NONE, rd: 5'd0,
                                  rj: 5'd0, rk: 5'd0, wen: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/dec3r_stage_classify.sv
// Combinational 3R op classifier; zero latency, no state.
// Disabled MUL/DIV units fold into the illegal result.
module dec3r_classify
   import dec3r_stage_pkg::*;
#(
   parameter bit EN_MUL = 1'b1,
   parameter bit EN_DIV = 1'b1
) (
   input  logic [31:0] instr,
   output logic [4:0]  op,
   output logic [1:0]  unit,
   output logic        illegal
);

   logic unused_bits;
   assign unused_bits = ^instr[14:0];

   always_comb begin
      op   = INVALID_OP_5B;
      unit = UNIT_NONE;
      if (instr[31:22] == 10'd0) begin
         case (instr[21:15])
            7'h20: begin op = _3R_ADD;   unit = UNIT_ALU; end
            7'h21: begin op = _3R_SUB;   unit = UNIT_ALU; end
            7'h24: begin op = _3R_SLT;   unit = UNIT_ALU; end
            7'h25: begin op = _3R_SLTU;  unit = UNIT_ALU; end
            7'h28: begin op = _3R_NOR;   unit = UNIT_ALU; end
            7'h29: begin op = _3R_AND;   unit = UNIT_ALU; end
            7'h2a: begin op = _3R_OR;    unit = UNIT_ALU; end
            7'h2b: begin op = _3R_XOR;   unit = UNIT_ALU; end
            7'h2e: begin op = _3R_SLL;   unit = UNIT_ALU; end
            7'h2f: begin op = _3R_SRL;   unit = UNIT_ALU; end
            7'h30: begin op = _3R_SRA;   unit = UNIT_ALU; end
            7'h38: begin op = _3R_MUL;   unit = UNIT_MUL; end
            7'h39: begin op = _3R_MULH;  unit = UNIT_MUL; end
            7'h3a: begin op = _3R_MULHU; unit = UNIT_MUL; end
            7'h40: begin op = _3R_DIV;   unit = UNIT_DIV; end
            7'h41: begin op = _3R_MOD;   unit = UNIT_DIV; end
            7'h42: begin op = _3R_DIVU;  unit = UNIT_DIV; end
            7'h43: begin op = _3R_MODU;  unit = UNIT_DIV; end
            default: ;
         endcase
      end
      // A recognised op on a unit that is not built is reported exactly like garbage.
      if ((unit == UNIT_MUL && !EN_MUL) || (unit == UNIT_DIV && !EN_DIV)) begin
         op   = INVALID_OP_5B;
         unit = UNIT_NONE;
      end
      illegal = (unit == UNIT_NONE);
   end

endmodule

// File: rtl/dec3r_stage.sv
// Registered 3R decode stage with a two-entry elastic buffer and saturating perf counters.
// Latency 1 cycle; in_ready is a pure register output (skid empty), so stalls never ripple upstream combinationally.
module dec3r_stage
   import dec3r_stage_pkg::*;
#(
   parameter bit EN_MUL = 1'b1,
   parameter bit EN_DIV = 1'b1,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_op,
   output logic [1:0]       out_unit,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rj,
   output logic [4:0]       out_rk,
   output logic             out_wen,
   output logic             out_illegal,
   output logic [PC_W-1:0]  out_pc,
   output logic [CNT_W-1:0] cnt_issued,
   output logic [CNT_W-1:0] cnt_illegal
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   meta_t           dec_cur, out_q, skid_q;
   logic [PC_W-1:0] out_pc_q, skid_pc_q;
   logic            out_vld_q, skid_vld_q;
   logic [4:0]      cls_op;
   logic [1:0]      cls_unit;
   logic            cls_ill;
   logic            accept, out_free, fire;

   dec3r_classify #(.EN_MUL(EN_MUL), .EN_DIV(EN_DIV)) u_classify (
      .instr   (in_instr),
      .op      (cls_op),
      .unit    (cls_unit),
      .illegal (cls_ill)
   );

   always_comb begin
      dec_cur.op      = cls_op;
      dec_cur.unit    = cls_unit;
      dec_cur.rd      = in_instr[4:0];
      dec_cur.rj      = in_instr[9:5];
      dec_cur.rk      = in_instr[14:10];
      dec_cur.illegal = cls_ill;
      dec_cur.wen     = !cls_ill && (in_instr[4:0] != 5'd0);
   end

   assign in_ready = !skid_vld_q;
   assign accept   = in_valid && !skid_vld_q;
   assign out_free = !out_vld_q || out_ready;
   assign fire     = out_vld_q && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         out_q      <= META_RST;
         skid_q     <= META_RST;
         out_pc_q   <= '0;
         skid_pc_q  <= '0;
      end else if (flush) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else if (out_free) begin
         if (skid_vld_q) begin
            out_q    <= skid_q;
            out_pc_q <= skid_pc_q;
         end else if (accept) begin
            out_q    <= dec_cur;
            out_pc_q <= in_pc;
         end
         out_vld_q  <= skid_vld_q || accept;
         skid_vld_q <= 1'b0;
      end else if (accept) begin
         skid_q     <= dec_cur;
         skid_pc_q  <= in_pc;
         skid_vld_q <= 1'b1;
      end
   end

   // A handshake completing in a flush cycle really left the stage, so it is still counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_issued  <= '0;
         cnt_illegal <= '0;
      end else if (fire) begin
         if (cnt_issued != CNT_MAX)
            cnt_issued <= cnt_issued + 1'b1;
         if (out_q.illegal && cnt_illegal != CNT_MAX)
            cnt_illegal <= cnt_illegal + 1'b1;
      end
   end

   assign out_valid   = out_vld_q;
   assign out_op      = out_q.op;
   assign out_unit    = out_q.unit;
   assign out_rd      = out_q.rd;
   assign out_rj      = out_q.rj;
   assign out_rk      = out_q.rk;
   assign out_wen     = out_q.wen;
   assign out_illegal = out_q.illegal;
   assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_dec3r_stage.sv
// Two stage instances share one stimulus stream: full-featured (16-bit counters) and MUL/DIV-less (4-bit counters).
// Reference is a queue of accepted words plus counters, decoded from the opcode table.
module tb_dec3r_stage;
   import dec3r_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        a_in_ready, a_out_valid, a_wen, a_ill;
   logic [4:0]  a_op, a_rd, a_rj, a_rk;
   logic [1:0]  a_unit;
   logic [31:0] a_pc;
   logic [15:0] a_ci, a_cl;

   logic        b_in_ready, b_out_valid, b_wen, b_ill;
   logic [4:0]  b_op, b_rd, b_rj, b_rk;
   logic [1:0]  b_unit;
   logic [31:0] b_pc;
   logic [3:0]  b_ci, b_cl;

   always #5 clk = ~clk;

   dec3r_stage #(.EN_MUL(1'b1), .EN_DIV(1'b1), .PC_W(32), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_op(a_op), .out_unit(a_unit), .out_rd(a_rd), .out_rj(a_rj), .out_rk(a_rk),
      .out_wen(a_wen), .out_illegal(a_ill), .out_pc(a_pc), .cnt_issued(a_ci), .cnt_illegal(a_cl));

   dec3r_stage #(.EN_MUL(1'b0), .EN_DIV(1'b0), .PC_W(32), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_op(b_op), .out_unit(b_unit), .out_rd(b_rd), .out_rj(b_rj), .out_rk(b_rk),
      .out_wen(b_wen), .out_illegal(b_ill), .out_pc(b_pc), .cnt_issued(b_ci), .cnt_illegal(b_cl));

   localparam logic [6:0] FUNCT [18] = '{7'h20, 7'h21, 7'h24, 7'h25, 7'h28, 7'h29, 7'h2a, 7'h2b,
                                        7'h2e, 7'h2f, 7'h30, 7'h38, 7'h39, 7'h3a, 7'h40, 7'h41,
                                        7'h42, 7'h43};
   localparam logic [4:0] OPS [18] = '{_3R_ADD, _3R_SUB, _3R_SLT, _3R_SLTU, _3R_NOR, _3R_AND,
                                      _3R_OR, _3R_XOR, _3R_SLL, _3R_SRL, _3R_SRA, _3R_MUL,
                                      _3R_MULH, _3R_MULHU, _3R_DIV, _3R_MOD, _3R_DIVU, _3R_MODU};

   int n_chk = 0, n_pass = 0;
   logic [31:0] q_ins[$], q_pc[$];
   int a_iss = 0, a_ilc = 0, b_iss = 0, b_ilc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic void ref_dec(input logic [31:0] w, input bit em, input bit ed,
                                   output logic [4:0] op, output logic [1:0] un, output logic ill);
      op = INVALID_OP_5B; un = UNIT_NONE;
      if (w[31:22] == 10'd0)
         for (int i = 0; i < 18; i++)
            if (w[21:15] == FUNCT[i]) begin
               op = OPS[i];
               un = (i < 11) ? UNIT_ALU : (i < 14) ? UNIT_MUL : UNIT_DIV;
            end
      if ((un == UNIT_MUL && !em) || (un == UNIT_DIV && !ed)) begin
         op = INVALID_OP_5B; un = UNIT_NONE;
      end
      ill = (un == UNIT_NONE);
   endfunction

   task automatic check_dut(input string nm, input logic ir, input logic ov, input logic [4:0] op,
                            input logic [1:0] un, input logic [4:0] rd, input logic [4:0] rj,
                            input logic [4:0] rk, input logic wen, input logic ill,
                            input logic [31:0] pc, input logic [15:0] ci, input logic [15:0] cl,
                            input bit em, input bit ed, input int ei, input int el);
      logic [4:0] eop; logic [1:0] eun; logic eill; logic [31:0] w;
      chk({nm, ".in_ready"}, 32'(ir), 32'(q_ins.size() < 2));
      chk({nm, ".out_valid"}, 32'(ov), 32'(q_ins.size() > 0));
      chk({nm, ".cnt_issued"}, 32'(ci), ei);
      chk({nm, ".cnt_illegal"}, 32'(cl), el);
      if (q_ins.size() > 0) begin
         w = q_ins[0];
         ref_dec(w, em, ed, eop, eun, eill);
         chk({nm, ".op"}, 32'(op), 32'(eop));
         chk({nm, ".unit"}, 32'(un), 32'(eun));
         chk({nm, ".rd"}, 32'(rd), 32'(w[4:0]));
         chk({nm, ".rj"}, 32'(rj), 32'(w[9:5]));
         chk({nm, ".rk"}, 32'(rk), 32'(w[14:10]));
         chk({nm, ".illegal"}, 32'(ill), 32'(eill));
         chk({nm, ".wen"}, 32'(wen), 32'(!eill && w[4:0] != 5'd0));
         chk({nm, ".pc"}, pc, q_pc[0]);
      end
   endtask

   task automatic check_all();
      check_dut("a", a_in_ready, a_out_valid, a_op, a_unit, a_rd, a_rj, a_rk, a_wen, a_ill, a_pc,
                a_ci, a_cl, 1'b1, 1'b1, a_iss, a_ilc);
      check_dut("b", b_in_ready, b_out_valid, b_op, b_unit, b_rd, b_rj, b_rk, b_wen, b_ill, b_pc,
                16'(b_ci), 16'(b_cl), 1'b0, 1'b0, b_iss, b_ilc);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, ".a_rst_vld_rdy"}, {a_out_valid, a_in_ready}, 32'd1);
      chk({nm, ".a_rst_cnt"}, {a_ci, a_cl}, 32'd0);
      chk({nm, ".a_rst_opunit"}, {a_op, a_unit}, {INVALID_OP_5B, UNIT_NONE});
      chk({nm, ".a_rst_fields"}, {a_rd, a_rj, a_rk, a_wen, a_ill}, 32'd0);
      chk({nm, ".a_rst_pc"}, a_pc, 32'd0);
      chk({nm, ".b_rst_vld_rdy"}, {b_out_valid, b_in_ready}, 32'd1);
      chk({nm, ".b_rst_cnt"}, {b_ci, b_cl}, 32'd0);
      chk({nm, ".b_rst_opunit"}, {b_op, b_unit}, {INVALID_OP_5B, UNIT_NONE});
      chk({nm, ".b_rst_fields"}, {b_rd, b_rj, b_rk, b_wen, b_ill}, 32'd0);
      chk({nm, ".b_rst_pc"}, b_pc, 32'd0);
   endtask

   function automatic void model_clear();
      q_ins.delete(); q_pc.delete();
      a_iss = 0; a_ilc = 0; b_iss = 0; b_ilc = 0;
   endfunction

   // Check the state left by the previous edge, then drive this cycle and advance the model.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
      logic [4:0] op; logic [1:0] un; logic ill; bit acc;
      @(negedge clk);
      check_all();
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      acc = v && (q_ins.size() < 2);
      if (q_ins.size() > 0 && ordy) begin
         ref_dec(q_ins[0], 1'b1, 1'b1, op, un, ill);
         if (a_iss < 65535) a_iss++;
         if (ill && a_ilc < 65535) a_ilc++;
         ref_dec(q_ins[0], 1'b0, 1'b0, op, un, ill);
         if (b_iss < 15) b_iss++;
         if (ill && b_ilc < 15) b_ilc++;
         void'(q_ins.pop_front()); void'(q_pc.pop_front());
      end
      if (acc) begin q_ins.push_back(ins); q_pc.push_back(pc); end
      if (fl) begin q_ins.delete(); q_pc.delete(); end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int sel;
      sel = $urandom_range(0, 99);
      w = $urandom;
      if (sel < 65) w = {10'd0, FUNCT[$urandom_range(0, 17)], w[14:0]};
      else if (sel < 80) w = {10'd0, w[21:0]};
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'd0; in_pc = 32'd0;
      repeat (2) @(negedge clk);
      check_reset("init");
      rst_n = 1'b1;

      step(1, 32'h00100823, 32'h1000, 1, 0);
      step(1, 32'h002018A4, 32'h1004, 1, 0);
      step(1, 32'h02800000, 32'h1008, 1, 0);
      step(1, 32'h00100820, 32'h100c, 1, 0);
      step(1, 32'h001C2507, 32'h1010, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h00108c41, 32'h2000, 0, 0);
      step(1, 32'h00110c62, 32'h2004, 0, 0);
      step(1, 32'h00209083, 32'h2008, 0, 0);
      step(1, 32'h00209083, 32'h2008, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 1, 0);

      step(1, 32'h00150c21, 32'h3000, 0, 0);
      step(1, 32'h00158c22, 32'h3004, 0, 0);
      step(1, 32'h00160c23, 32'h3008, 0, 1);
      step(1, 32'h00168c24, 32'h300c, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
              $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("async");
      model_clear();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
              $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
